// File: rtl/sb_position_sequencer.sv
// rtl/sb_position_sequencer.sv - position-update initiator with inelastic wall, optional WAIT timeout (SB_SEQ_TIMEOUT_EN)
module sb_position_sequencer #(
    parameter int N              = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_WIDTH     = 16,
    parameter int STEP_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [N*DATA_WIDTH-1:0] load_x,
    input  logic [N*DATA_WIDTH-1:0] load_y,
    input  logic                    start,
    input  logic [STEP_WIDTH-1:0]   num_steps,
    input  logic [DATA_WIDTH-1:0]   dt_cfg,
    output logic                    upd_valid,
    output logic [N*DATA_WIDTH-1:0] upd_x,
    output logic [N*DATA_WIDTH-1:0] upd_y,
    output logic [DATA_WIDTH-1:0]   upd_dt,
    input  logic                    upd_resp_valid,
    input  logic [N*DATA_WIDTH-1:0] upd_x_next,
    output logic [N*DATA_WIDTH-1:0] x_state,
    output logic [N*DATA_WIDTH-1:0] y_state,
    output logic [N-1:0]            spin,
    output logic [STEP_WIDTH-1:0]   step_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic signed [DATA_WIDTH-1:0] ONE =
        {{(DATA_WIDTH-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] NEG_ONE = -ONE;
    localparam logic [STEP_WIDTH-1:0] STEP_INC = 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t                    state;
    logic [N*DATA_WIDTH-1:0]   x_q;
    logic [N*DATA_WIDTH-1:0]   y_q;
    logic [N*DATA_WIDTH-1:0]   xn_q;
    logic [DATA_WIDTH-1:0]     dt_q;
    logic [STEP_WIDTH-1:0]     steps_q;
    logic [N*DATA_WIDTH-1:0]   x_wb;
    logic [N*DATA_WIDTH-1:0]   y_wb;
    logic [STEP_WIDTH-1:0]     step_next;

`ifdef SB_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_INC  = 1;
    logic [CW-1:0] wait_cnt;
`else
    assign error = 1'b0;
`endif

    assign upd_x      = x_q;
    assign upd_y      = y_q;
    assign upd_dt     = dt_q;
    assign x_state    = x_q;
    assign y_state    = y_q;
    assign step_next  = step_count + STEP_INC;

    // Sign bit of each position is the oscillator's spin.
    always_comb begin
        spin = '0;
        for (int i = 0; i < N; i++) begin
            spin[i] = x_q[i*DATA_WIDTH + DATA_WIDTH-1];
        end
    end

    // Inelastic wall: a position past +/-ONE is pinned to the wall and loses its momentum.
    always_comb begin
        x_wb = xn_q;
        y_wb = y_q;
        for (int i = 0; i < N; i++) begin
            if ($signed(xn_q[i*DATA_WIDTH +: DATA_WIDTH]) > ONE) begin
                x_wb[i*DATA_WIDTH +: DATA_WIDTH] = ONE;
                y_wb[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ($signed(xn_q[i*DATA_WIDTH +: DATA_WIDTH]) < NEG_ONE) begin
                x_wb[i*DATA_WIDTH +: DATA_WIDTH] = NEG_ONE;
                y_wb[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Run sequencer: state, oscillator registers and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            xn_q       <= '0;
            dt_q       <= '0;
            steps_q    <= '0;
            step_count <= '0;
            upd_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SB_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
            error      <= 1'b0;
`endif
        end else begin
            upd_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_valid) begin
                        x_q <= load_x;
                        y_q <= load_y;
                    end
                    if (start) begin
                        steps_q    <= num_steps;
                        dt_q       <= dt_cfg;
                        step_count <= '0;
                        busy       <= 1'b1;
`ifdef SB_SEQ_TIMEOUT_EN
                        error      <= 1'b0;
`endif
                        if (num_steps == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            upd_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef SB_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (upd_resp_valid) begin
                        xn_q  <= upd_x_next;
                        state <= S_WRITEBACK;
`ifdef SB_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_INC;
`endif
                    end
                end
                S_WRITEBACK: begin
                    x_q        <= x_wb;
                    y_q        <= y_wb;
                    step_count <= step_next;
                    if (step_next == steps_q) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_ISSUE;
                        upd_valid <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_position_sequencer.sv
// tb/tb_sb_position_sequencer.sv - scoreboard bench for sb_position_sequencer (N=2)
module tb_sb_position_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [63:0] load_x;
    logic [63:0] load_y;
    logic        start;
    logic [15:0] num_steps;
    logic [31:0] dt_cfg;
    logic        upd_valid;
    logic [63:0] upd_x;
    logic [63:0] upd_y;
    logic [31:0] upd_dt;
    logic        upd_resp_valid;
    logic [63:0] upd_x_next;
    logic [63:0] x_state;
    logic [63:0] y_state;
    logic [1:0]  spin;
    logic [15:0] step_count;
    logic        busy;
    logic        done;
    logic        error;

    sb_position_sequencer #(.N(2), .DATA_WIDTH(32), .FRAC_WIDTH(16), .STEP_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_x(load_x), .load_y(load_y),
        .start(start), .num_steps(num_steps), .dt_cfg(dt_cfg), .upd_valid(upd_valid),
        .upd_x(upd_x), .upd_y(upd_y), .upd_dt(upd_dt), .upd_resp_valid(upd_resp_valid),
        .upd_x_next(upd_x_next), .x_state(x_state), .y_state(y_state), .spin(spin),
        .step_count(step_count), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [15:0] steps;
        logic [1:0]  spin;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    bit   model_en = 1'b1;
    bit   pend = 1'b0;
    logic [63:0] pend_x;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] upd_model(input logic [63:0] x, input logic [63:0] y, input logic [31:0] dt);
        logic [63:0]        r;
        logic signed [63:0] p;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            p = $signed(y[i*32 +: 32]) * $signed(dt);
            r[i*32 +: 32] = x[i*32 +: 32] + p[47:16];
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Updater stand-in with 1-cycle latency.
    always @(negedge clk) begin
        if (model_en) begin
            upd_resp_valid = pend;
            upd_x_next     = pend_x;
            pend           = upd_valid;
            if (upd_valid) pend_x = upd_model(upd_x, upd_y, upd_dt);
        end
    end

    // Monitor: record request pulses; on each done pop and compare the expected final state.
    always @(negedge clk) begin
        exp_t e;
        if (upd_valid) pulse_cyc.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_x_state", x_state, e.x);
                chk("sb_y_state", y_state, e.y);
                chk("sb_step_count", 64'(step_count), 64'(e.steps));
                chk("sb_spin", 64'(spin), 64'(e.spin));
            end
        end
    end

    task automatic do_load(input logic [63:0] x, input logic [63:0] y);
        load_valid = 1'b1;
        load_x     = x;
        load_y     = y;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic run(input logic [15:0] steps, input logic [31:0] dt, input int inj,
                       output int start_c, output int end_c);
        int k;
        pulse_cyc.delete();
        start     = 1'b1;
        num_steps = steps;
        dt_cfg    = dt;
        start_c   = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (busy && k < 300) begin
            if (k == inj) begin
                load_valid = 1'b1;
                load_x     = 64'h1111_1111_2222_2222;
                load_y     = 64'h3333_3333_4444_4444;
                start      = 1'b1;
                num_steps  = 16'd7;
            end else begin
                load_valid = 1'b0;
                start      = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
        end_c      = cyc;
        chk("run_terminates", 64'(busy), 64'd0);
    endtask

    initial begin
        int sc, ec, dc0;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, ec, dc0;
        rst_n = 1'b0; load_valid = 1'b0; load_x = '0; load_y = '0; start = 1'b0;
        num_steps = '0; dt_cfg = '0; upd_resp_valid = 1'b0; upd_x_next = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_x_state", x_state, 64'd0);
        chk("rst_y_state", y_state, 64'd0);
        chk("rst_step_count", 64'(step_count), 64'd0);
        chk("rst_busy_done_err_valid", {60'd0, busy, done, error, upd_valid}, 64'd0);
        chk("rst_upd_dt", 64'(upd_dt), 64'd0);

        // Basic step
        do_load(64'h0, 64'hFFFF8000_00008000);
        exp_q.push_back('{x: 64'hFFFFE000_00002000, y: 64'hFFFF8000_00008000, steps: 16'd1, spin: 2'b10});
        dc0 = done_cnt;
        run(16'd1, 32'h4000, -1, sc, ec);
        chk("basic_done_count", 64'(done_cnt - dc0), 64'd1);
        chk("basic_pulses", 64'(pulse_cyc.size()), 64'd1);

        // Wall clamp
        do_load(64'hFFFF1000_0000F000, 64'hFFFF0000_00010000);
        exp_q.push_back('{x: 64'hFFFF0000_00010000, y: 64'h0, steps: 16'd1, spin: 2'b10});
        run(16'd1, 32'h4000, -1, sc, ec);

        // Multi-step, with load/start injected mid-run (must be ignored)
        do_load(64'h0, 64'hFFFFF000_00001000);
        exp_q.push_back('{x: 64'hFFFFF000_00001000, y: 64'hFFFFF000_00001000, steps: 16'd4, spin: 2'b10});
        dc0 = done_cnt;
        run(16'd4, 32'h4000, 3, sc, ec);
        chk("multi_pulses", 64'(pulse_cyc.size()), 64'd4);
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk("multi_spacing", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'd3);
        if (pulse_cyc.size() == 4)
            chk("multi_done_after_last_wb", 64'(done_cyc - pulse_cyc[3]), 64'd3);
        chk("multi_done_count", 64'(done_cnt - dc0), 64'd1);
        chk("multi_step_count", 64'(step_count), 64'd4);

        // Zero steps: no request, done one cycle after start, state unchanged
        exp_q.push_back('{x: 64'hFFFFF000_00001000, y: 64'hFFFFF000_00001000, steps: 16'd0, spin: 2'b10});
        run(16'd0, 32'h1234, -1, sc, ec);
        chk("zero_pulses", 64'(pulse_cyc.size()), 64'd0);
        chk("zero_done_latency", 64'(done_cyc - sc), 64'd1);
        chk("zero_dt_latched", 64'(upd_dt), 64'h1234);

        // Stray response in IDLE
        model_en = 1'b0;
        dc0 = done_cnt;
        upd_resp_valid = 1'b1;
        upd_x_next = 64'h7777_7777_8888_8888;
        @(negedge clk);
        upd_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_x_state", x_state, 64'hFFFFF000_00001000);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_no_done", 64'(done_cnt - dc0), 64'd0);

`ifdef SB_SEQ_TIMEOUT_EN
        // Timeout with no response: error, back to IDLE, no done
        dc0 = done_cnt;
        run(16'd1, 32'h4000, -1, sc, ec);
        chk("to_error", 64'(error), 64'd1);
        chk("to_duration", 64'(ec - sc), 64'd66);
        chk("to_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("to_x_kept", x_state, 64'hFFFFF000_00001000);
`else
        chk("error_tied_low", 64'(error), 64'd0);
`endif

        // Reset while WAITing: everything clears, no done
        dc0 = done_cnt;
        start = 1'b1; num_steps = 16'd2; dt_cfg = 32'h4000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x_y", x_state | y_state, 64'd0);
        chk("mid_rst_flags", {60'd0, busy, done, error, upd_valid}, 64'd0);
        chk("mid_rst_dt_steps", {16'd0, upd_dt, step_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("post_rst_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
